de2_input_conditioner: RTL
==========================

// Module: de2_input_conditioner
// PURPOSE
//  Conditions raw DE2 board inputs (active-low KEY buttons, SW slide switches) before the SoC GPIO sees them.
//  Sits inside de2_wrapper between the board pins and the SoC input port.
//  Per input: 2-FF synchroniser plus debounce counter. Provides clean levels, 1-cycle press pulses and
//  sticky press flags with a per-key ack handshake.
// PARAMETERS
//  NUM_KEYS         2        number of push-button inputs (KEY_N width)
//  NUM_SW           16       number of slide-switch inputs (SW width)
//  DEBOUNCE_CYCLES  500000   consecutive stable cycles before a level change is accepted (>=1; bench uses 8)
// PORTS
//  CLOCK_50     in   1            system clock, all logic on rising edge
//  Reset        in   1            asynchronous, active-high reset
//  KEY_N        in   NUM_KEYS     raw buttons, 0 = pressed, asynchronous to CLOCK_50
//  SW           in   NUM_SW       raw switches, asynchronous to CLOCK_50
//  btn_level    out  NUM_KEYS     debounced button state, 1 = pressed
//  btn_press    out  NUM_KEYS     1-cycle pulse on debounced 0->1 of btn_level
//  btn_event    out  NUM_KEYS     sticky press flag, held until acked
//  btn_ack      in   NUM_KEYS     clears btn_event[i] (from SoC GPIO read)
//  sw_stable    out  NUM_SW       debounced switch levels
//  sw_change    out  1            1-cycle pulse when any sw_stable bit changes
//  press_count  out  NUM_KEYS*8   per-key 8-bit press counter, key i at [8i+7:8i] (see CONFIGURATION)
// BEHAVIOUR
//  Reset values (asserted asynchronously):
//   - Key sync FFs = 1 (released); switch sync FFs = 0.
//   - All debounce counters = 0.
//   - btn_level, btn_press, btn_event, sw_stable, sw_change, press_count = 0.
//  Synchroniser: 2 FFs per input. Key path inverted after sync, so raw_s = 1 means pressed.
//  Debounce, per input, counter width $clog2(DEBOUNCE_CYCLES+1):
//   - raw_s == stable: cnt <= 0.
//   - raw_s != stable and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
//   - raw_s != stable and cnt == DEBOUNCE_CYCLES-1: stable <= raw_s, cnt <= 0.
//   - Any single-cycle return to the stable level restarts the count (bounce rejection).
//  Latency: pin change before edge k -> stable updates on edge k+DEBOUNCE_CYCLES+1 (DEBOUNCE_CYCLES+2 cycles).
//  btn_press[i]: registered. High only in the first cycle btn_level[i]==1 after a 0->1 change. Never on release.
//  btn_event[i] (next state, priority order):
//   1. btn_press[i] condition -> 1 (a new press beats a simultaneous ack).
//   2. btn_ack[i] -> 0.
//   3. otherwise hold.
//   - Ack while btn_event==0 is ignored.
//  sw_change: registered. High in the first cycle sw_stable differs from its previous value; several bits
//   settling on the same edge produce one pulse.
//  Inputs are independent: simultaneous activity on different keys/switches needs no arbitration.
//  Reset mid-debounce: counts are discarded. A key still held at reset release is re-detected as a press after
//   DEBOUNCE_CYCLES+2 cycles.
// CONFIGURATION
//  PRESS_COUNT_EN defined:
//   - press_count[8i+7:8i] increments on each btn_press[i], wraps 255 -> 0.
//   - Cleared only by Reset.
//  PRESS_COUNT_EN undefined: no counter logic; press_count tied to 0.
// TESTING (DEBOUNCE_CYCLES=8, CLOCK_50 period 20ns)
//  1 Reset pulse, KEY_N=2'b11, SW=0, run 20 cycles
//     -> all outputs 0, no btn_press or sw_change pulse.
//  2 KEY_N[0]=0 for 50 cycles
//     -> btn_level[0]=1 exactly 10 cycles after pin change; one btn_press[0] pulse; btn_event[0]=1 until btn_ack[0].
//  3 KEY_N[1] toggles every 3 cycles for 30 cycles, then held 0
//     -> no pulse during bounce; exactly one btn_press[1] 10 cycles after settling.
//  4 btn_ack[0] in the same cycle as a new btn_press[0]
//     -> btn_event[0] stays 1. Ack alone -> btn_event[0]=0 next cycle.
//  5 SW 0->16'h0005 held; later SW[3] glitch of 4 cycles
//     -> sw_stable=5 after 10 cycles with one sw_change pulse; glitch gives no change.
//  6 Reset asserted at cnt=5 during a key press
//     -> outputs 0 immediately; press re-detected 10 cycles after release.
//    With PRESS_COUNT_EN: 257 presses on key 0 -> press_count[7:0]=1. Without the macro: stays 0.

Source files
------------

// File: rtl/de2_input_conditioner.sv
// DE2 KEY/SW input conditioner: 2-FF sync + debounce per pin, press pulses, sticky events.
// Optional per-key 8-bit press counters are built when PRESS_COUNT_EN is defined.

module de2_debounce #(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter bit RST_VAL         = 1'b0,
  parameter bit INVERT          = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic stable_o,
  output logic flip_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          raw_s;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q   <= {2{RST_VAL}};
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], pin_i};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  // Polarity is fixed after the synchroniser so the sync FFs see the raw pin.
  assign raw_s = sync_q[1] ^ INVERT;

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    flip_o   = 1'b0;
    if (raw_s == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      stable_d = raw_s;
      cnt_d    = '0;
      flip_o   = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign stable_o = stable_q;
endmodule

module de2_input_conditioner #(
  parameter int NUM_KEYS        = 2,
  parameter int NUM_SW          = 16,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                  CLOCK_50,
  input  logic                  Reset,
  input  logic [NUM_KEYS-1:0]   KEY_N,
  input  logic [NUM_SW-1:0]     SW,
  output logic [NUM_KEYS-1:0]   btn_level,
  output logic [NUM_KEYS-1:0]   btn_press,
  output logic [NUM_KEYS-1:0]   btn_event,
  input  logic [NUM_KEYS-1:0]   btn_ack,
  output logic [NUM_SW-1:0]     sw_stable,
  output logic                  sw_change,
  output logic [NUM_KEYS*8-1:0] press_count
);
  logic [NUM_KEYS-1:0] key_stable, key_flip, key_rise;
  logic [NUM_SW-1:0]   sw_flip;
  logic [NUM_KEYS-1:0] press_q, event_q, event_d;
  logic                swchg_q;

  de2_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b1), .INVERT(1'b1)) u_key [NUM_KEYS-1:0] (
    .clk_i   (CLOCK_50),
    .rst_i   (Reset),
    .pin_i   (KEY_N),
    .stable_o(key_stable),
    .flip_o  (key_flip)
  );

  de2_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b0), .INVERT(1'b0)) u_sw [NUM_SW-1:0] (
    .clk_i   (CLOCK_50),
    .rst_i   (Reset),
    .pin_i   (SW),
    .stable_o(sw_stable),
    .flip_o  (sw_flip)
  );

  // A flip while currently released is a debounced press.
  assign key_rise = key_flip & ~key_stable;
  // Visible press pulse wins over an ack presented in the same cycle.
  assign event_d  = press_q | (event_q & ~btn_ack);

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      press_q <= '0;
      event_q <= '0;
      swchg_q <= 1'b0;
    end else begin
      press_q <= key_rise;
      event_q <= event_d;
      swchg_q <= |sw_flip;
    end
  end

  assign btn_level = key_stable;
  assign btn_press = press_q;
  assign btn_event = event_q;
  assign sw_change = swchg_q;

`ifdef PRESS_COUNT_EN
  logic [NUM_KEYS-1:0][7:0] pcnt_q;

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      pcnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++)
        if (press_q[i]) pcnt_q[i] <= pcnt_q[i] + 8'd1;
    end
  end

  assign press_count = pcnt_q;
`else
  assign press_count = '0;
`endif
endmodule
